// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and default geometry for the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } icache_state_e;

  localparam int unsigned ICACHE_SETS           = 16;
  localparam int unsigned ICACHE_WORDS_PER_LINE = 4;

endpackage

`default_nettype wire

// File: rtl/icache_if.sv
// ============================================================================
// Module      : icache_if
// Description : Refill request/response bus between the icache and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_if;
  logic        mem_req_v_o;
  logic [31:0] mem_addr_o;
  logic        mem_req_ready_i;
  logic        mem_resp_v_i;
  logic [31:0] mem_resp_data_i;

  modport master (
    output mem_req_v_o,
    output mem_addr_o,
    input  mem_req_ready_i,
    input  mem_resp_v_i,
    input  mem_resp_data_i
  );

  modport slave (
    input  mem_req_v_o,
    input  mem_addr_o,
    output mem_req_ready_i,
    output mem_resp_v_i,
    output mem_resp_data_i
  );
endinterface

`default_nettype wire

// File: rtl/icache_ctl.sv
// ============================================================================
// Module      : icache_ctl
// Description : Miss/refill FSM, beat counter, drop flag and handshake outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_ctl
  import icache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
  parameter int unsigned BW             = $clog2(WORDS_PER_LINE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          raw_hit_i,
  input  logic          mem_req_ready_i,
  input  logic          mem_resp_v_i,
  output logic          hit_o,
  output logic          stall_o,
  output logic          mem_req_v_o,
  output logic          latch_o,
  output logic          fill_we_o,
  output logic          fill_last_o,
  output logic          install_valid_o,
  output logic [BW-1:0] beat_o
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);

  icache_state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          drop_q, drop_d;
  logic          hit;

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    drop_d          = drop_q;
    hit             = 1'b0;
    mem_req_v_o     = 1'b0;
    latch_o         = 1'b0;
    fill_we_o       = 1'b0;
    fill_last_o     = 1'b0;
    install_valid_o = !drop_q && !flush_i;
    unique case (state_q)
      IDLE: begin
        hit = raw_hit_i && !flush_i;
        if (!hit) begin
          latch_o = 1'b1;
          drop_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_v_o = 1'b1;
        if (flush_i) drop_d = 1'b1;
        if (mem_req_ready_i) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        // A flush mid-refill still lets the line finish, but it lands invalid.
        if (flush_i) drop_d = 1'b1;
        if (mem_resp_v_i) begin
          fill_we_o = 1'b1;
          beat_d    = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            fill_last_o = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drop_q  <= drop_d;
    end
  end

  assign hit_o   = hit;
  assign stall_o = !hit;
  assign beat_o  = beat_q;

endmodule

`default_nettype wire

// File: rtl/icache_dp.sv
// ============================================================================
// Module      : icache_dp
// Description : Valid/tag/data storage, lookup compare, word mux, line address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_dp
  import icache_pkg::*;
#(
  parameter int unsigned SETS           = ICACHE_SETS,
  parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
  parameter int unsigned BW             = $clog2(WORDS_PER_LINE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   imem_addr_i,
  input  logic          flush_i,
  input  logic          hit_i,
  input  logic          latch_i,
  input  logic          fill_we_i,
  input  logic          fill_last_i,
  input  logic          install_valid_i,
  input  logic [BW-1:0] beat_i,
  input  logic          req_v_i,
  input  logic [31:0]   mem_resp_data_i,
  output logic          raw_hit_o,
  output logic [31:0]   imem_data_o,
  output logic [31:0]   mem_addr_o
);

  localparam int unsigned IB     = $clog2(SETS);
  localparam int unsigned IDX_LO = 2 + BW;
  localparam int unsigned TAG_LO = IDX_LO + IB;
  localparam int unsigned TB     = 32 - TAG_LO;

  logic [SETS-1:0] valid_q, valid_d;
  logic [TB-1:0]   tag_q  [SETS];
  logic [TB-1:0]   tag_d  [SETS];
  logic [31:0]     data_q [SETS][WORDS_PER_LINE];
  logic [31:0]     data_d [SETS][WORDS_PER_LINE];
  logic [31:0]     line_addr_q, line_addr_d;

  logic [IB-1:0]   idx, fill_idx;
  logic [BW-1:0]   word_sel;
  logic [TB-1:0]   tag_in, fill_tag;
  logic            unused_addr;

  assign idx         = imem_addr_i[TAG_LO-1:IDX_LO];
  assign word_sel    = imem_addr_i[IDX_LO-1:2];
  assign tag_in      = imem_addr_i[31:TAG_LO];
  assign fill_idx    = line_addr_q[TAG_LO-1:IDX_LO];
  assign fill_tag    = line_addr_q[31:TAG_LO];
  assign unused_addr = ^imem_addr_i[1:0];

  assign raw_hit_o   = valid_q[idx] && (tag_q[idx] == tag_in);
  assign imem_data_o = hit_i ? data_q[idx][word_sel] : 32'd0;
  assign mem_addr_o  = req_v_i ? line_addr_q : 32'd0;

  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    line_addr_d = line_addr_q;
    if (latch_i) line_addr_d = {imem_addr_i[31:IDX_LO], {IDX_LO{1'b0}}};
    if (fill_we_i) data_d[fill_idx][beat_i] = mem_resp_data_i;
    if (fill_last_i) begin
      tag_d[fill_idx]   = fill_tag;
      valid_d[fill_idx] = install_valid_i;
    end
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      line_addr_q <= '0;
    end else begin
      valid_q     <= valid_d;
      line_addr_q <= line_addr_d;
    end
  end

  // Tag and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module      : icache
// Description : Direct-mapped read-only instruction cache (control + datapath).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int unsigned SETS           = ICACHE_SETS,
  parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_stall_o,
  input  logic        flush_i,
  icache_if.master    mem
);

  localparam int unsigned BW = $clog2(WORDS_PER_LINE);

  logic          raw_hit, hit, req_v, latch, fill_we, fill_last, install_valid;
  logic [BW-1:0] beat;
  logic [31:0]   mem_addr;

  icache_ctl #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .BW             (BW)
  ) u_ctl (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .raw_hit_i       (raw_hit),
    .mem_req_ready_i (mem.mem_req_ready_i),
    .mem_resp_v_i    (mem.mem_resp_v_i),
    .hit_o           (hit),
    .stall_o         (imem_stall_o),
    .mem_req_v_o     (req_v),
    .latch_o         (latch),
    .fill_we_o       (fill_we),
    .fill_last_o     (fill_last),
    .install_valid_o (install_valid),
    .beat_o          (beat)
  );

  icache_dp #(
    .SETS           (SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .BW             (BW)
  ) u_dp (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_addr_i     (imem_addr_i),
    .flush_i         (flush_i),
    .hit_i           (hit),
    .latch_i         (latch),
    .fill_we_i       (fill_we),
    .fill_last_i     (fill_last),
    .install_valid_i (install_valid),
    .beat_i          (beat),
    .req_v_i         (req_v),
    .mem_resp_data_i (mem.mem_resp_data_i),
    .raw_hit_o       (raw_hit),
    .imem_data_o     (imem_data_o),
    .mem_addr_o      (mem_addr)
  );

  assign mem.mem_req_v_o = req_v;
  assign mem.mem_addr_o  = mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module      : tb_icache
// Description : Directed scoreboard bench for the icache refill and lookup paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        stall;
  logic        flush;
  logic        mon_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_req_q  [$];
  logic [31:0] exp_data_q [$];

  icache_if mem_if ();

  icache #(
    .SETS           (16),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_addr_i  (addr),
    .imem_data_o  (rdata),
    .imem_stall_o (stall),
    .flush_i      (flush),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented request or hit word is matched against the queues.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mem_if.mem_req_v_o) begin
        if (exp_req_q.size() == 0) chk("unexpected_req", mem_if.mem_addr_o, 32'hFFFF_FFFF);
        else begin
          chk("req_addr", mem_if.mem_addr_o, exp_req_q[0]);
          if (mem_if.mem_req_ready_i) void'(exp_req_q.pop_front());
        end
      end
      if (!stall) begin
        if (exp_data_q.size() == 0) chk("unexpected_hit", rdata, 32'hFFFF_FFFF);
        else chk("hit_data", rdata, exp_data_q.pop_front());
      end else begin
        chk("data_zero_on_stall", rdata, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall_now();
    #2;
    chk("stall", {31'd0, stall}, 32'd1);
  endtask

  // Entered at the start of the REQ cycle; leaves after the last beat cycle.
  task automatic serve_line(input logic [31:0] d0, input int rdy_wait,
                            input bit stray, input int flush_beat);
    for (int i = 0; i < rdy_wait; i++) begin
      mem_if.mem_req_ready_i = 1'b0;
      mem_if.mem_resp_v_i    = stray && (i == 0);
      mem_if.mem_resp_data_i = 32'hDEAD_BEEF;
      chk_stall_now();
      tick();
    end
    mem_if.mem_req_ready_i = 1'b1;
    mem_if.mem_resp_v_i    = stray;
    mem_if.mem_resp_data_i = 32'hBAD0_BAD0;
    chk_stall_now();
    tick();
    mem_if.mem_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_if.mem_resp_v_i    = 1'b1;
      mem_if.mem_resp_data_i = d0 + 32'(i);
      flush                  = (i == flush_beat);
      chk_stall_now();
      tick();
    end
    mem_if.mem_resp_v_i = 1'b0;
    flush               = 1'b0;
  endtask

  // Miss on a, refill with d0.., then one hit cycle returning hit_word.
  task automatic miss_fill_hit(input logic [31:0] a, input logic [31:0] line,
                               input logic [31:0] d0, input logic [31:0] hit_word,
                               input int rdy_wait, input bit stray);
    addr = a;
    exp_req_q.push_back(line);
    exp_data_q.push_back(hit_word);
    chk_stall_now();
    tick();
    serve_line(d0, rdy_wait, stray, -1);
    tick();
  endtask

  task automatic hit_at(input logic [31:0] a, input logic [31:0] w);
    addr = a;
    exp_data_q.push_back(w);
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    addr  = 32'h0000_0104;
    flush = 1'b0;
    mem_if.mem_req_ready_i = 1'b0;
    mem_if.mem_resp_v_i    = 1'b0;
    mem_if.mem_resp_data_i = 32'd0;
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Cold miss: reset-state outputs, then six stall cycles and word 1.
    exp_req_q.push_back(32'h0000_0100);
    exp_data_q.push_back(32'h0000_00A1);
    #2;
    chk("reset_stall", {31'd0, stall}, 32'd1);
    chk("reset_req_v", {31'd0, mem_if.mem_req_v_o}, 32'd0);
    chk("reset_mem_addr", mem_if.mem_addr_o, 32'd0);
    chk("reset_data", rdata, 32'd0);
    tick();
    serve_line(32'h0000_00A0, 0, 1'b0, -1);
    tick();

    hit_at(32'h0000_0100, 32'h0000_00A0);
    hit_at(32'h0000_0108, 32'h0000_00A2);
    hit_at(32'h0000_010C, 32'h0000_00A3);

    // Conflict eviction in set 0.
    miss_fill_hit(32'h0000_0200, 32'h0000_0200, 32'h0000_00B0, 32'h0000_00B0, 0, 1'b0);
    miss_fill_hit(32'h0000_0100, 32'h0000_0100, 32'h0000_00C0, 32'h0000_00C0, 0, 1'b0);

    // Backpressure with stray beats in REQ and on the handshake cycle.
    miss_fill_hit(32'h0000_0348, 32'h0000_0340, 32'h0000_00D0, 32'h0000_00D2, 3, 1'b1);
    hit_at(32'h0000_0340, 32'h0000_00D0);
    hit_at(32'h0000_0344, 32'h0000_00D1);
    hit_at(32'h0000_034C, 32'h0000_00D3);

    // Flush on beat 2: line lands invalid, the same address refills again.
    addr = 32'h0000_0454;
    exp_req_q.push_back(32'h0000_0450);
    chk_stall_now();
    tick();
    serve_line(32'h0000_0EE0, 0, 1'b0, 2);
    miss_fill_hit(32'h0000_0454, 32'h0000_0450, 32'h0000_00E0, 32'h0000_00E1, 0, 1'b0);

    // Flush on the final beat.
    addr = 32'h0000_0560;
    exp_req_q.push_back(32'h0000_0560);
    chk_stall_now();
    tick();
    serve_line(32'h0000_0FF0, 0, 1'b0, 3);
    miss_fill_hit(32'h0000_0560, 32'h0000_0560, 32'h0000_00F0, 32'h0000_00F0, 0, 1'b0);

    // Reset after beat 1; late beats must be ignored.
    addr = 32'h0000_0670;
    exp_req_q.push_back(32'h0000_0670);
    chk_stall_now();
    tick();
    mem_if.mem_req_ready_i = 1'b1;
    tick();
    mem_if.mem_req_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_if.mem_resp_v_i    = 1'b1;
      mem_if.mem_resp_data_i = 32'h0000_5550 + 32'(i);
      tick();
    end
    rst = 1'b1;
    mem_if.mem_resp_data_i = 32'h0000_5552;
    tick();
    rst = 1'b0;
    mem_if.mem_resp_data_i = 32'h0000_5553;
    exp_req_q.push_back(32'h0000_0670);
    exp_data_q.push_back(32'h0000_1000);
    #2;
    chk("rst_mid_stall", {31'd0, stall}, 32'd1);
    chk("rst_mid_req_v", {31'd0, mem_if.mem_req_v_o}, 32'd0);
    chk("rst_mid_mem_addr", mem_if.mem_addr_o, 32'd0);
    tick();
    serve_line(32'h0000_1000, 1, 1'b1, -1);
    tick();
    hit_at(32'h0000_0674, 32'h0000_1001);

    // Flush in IDLE on a resident line forces a stall and a refill.
    addr  = 32'h0000_0674;
    flush = 1'b1;
    exp_req_q.push_back(32'h0000_0670);
    exp_data_q.push_back(32'h0000_2001);
    chk_stall_now();
    tick();
    flush = 1'b0;
    serve_line(32'h0000_2000, 0, 1'b0, -1);
    tick();

    mon_en = 1'b0;
    chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    chk("data_queue_drained", 32'(exp_data_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction-memory port. On a hit it returns the addressed word in the same cycle. On a miss it raises a stall and refills one line from backing memory through a request/response handshake. It sits between `ifetch_stage` (`imem_addr_o`/`imem_data_i`, with `imem_stall_o` ORed into the fetch `stall_v_i`) and the memory system.

## Interface
- `SETS`, default 16: number of lines; power of two, at least 2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; power of two, at least 2.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `imem_addr_i`  in  32  fetch address, `rvga_word`; bits [1:0] ignored.
- `imem_data_o`  out  32  instruction word when `imem_stall_o`=0; 0 otherwise.
- `imem_stall_o`  out  1  1 = data not valid this cycle.
- `flush_i`  in  1  invalidate all lines (fence.i).
- `mem_req_v_o`  out  1  refill request valid.
- `mem_addr_o`  out  32  line-aligned refill address; 0 when `mem_req_v_o`=0.
- `mem_req_ready_i`  in  1  memory accepts the request.
- `mem_resp_v_i`  in  1  one refill beat valid.
- `mem_resp_data_i`  in  32  refill beat data; beats arrive in ascending word order.

## Operation
- Address split, using default values: word = [3:2], index = [7:4], tag = [31:8]. Widths in general are `log2(WORDS_PER_LINE)`, `log2(SETS)`, and the remainder.
- Storage is flops:
  - per-set valid bit (reset to 0);
  - tag (not reset);
  - data words (not reset).
- Hit = `state==IDLE` && valid[index] && tag match && !`flush_i`. `imem_stall_o` = !hit.
- States:
  - IDLE:
    - On a hit, drive the word. No state change.
    - On a miss, latch the line address (`imem_addr_i` with index and tag bits kept, low bits zeroed), clear `drop`, and go to REQ.
  - REQ: `mem_req_v_o`=1 and `mem_addr_o`=latched line address, both held until `mem_req_ready_i`. On ready, set beat=0 and go to FILL.
  - FILL:
    - Each `mem_resp_v_i` writes data[latched index][beat], then beat+1.
    - On beat `WORDS_PER_LINE`-1, write the tag, set valid = !`drop` && !`flush_i`, and go to IDLE.
- `mem_resp_v_i` outside FILL is ignored.
- `flush_i` clears every valid bit the same cycle it is asserted. If asserted in REQ or FILL, it also sets `drop`; the fill still completes, but the line is installed invalid.
- If `imem_addr_i` changes during REQ/FILL (branch or flush in fetch), the refill still completes for the latched address. IDLE then re-evaluates the current address, which may cause a new miss.
- There is only one outstanding refill at any time.

## Timing
- Hit: 0-cycle latency; the word is combinational from `imem_addr_i`.
- Miss:
  - cycle 0: miss detected, stall=1;
  - cycle 1: REQ;
  - with ready in cycle 1, beats are accepted from cycle 2;
  - the last beat is accepted in cycle L;
  - cycle L+1: IDLE, hit, stall=0.
  - Minimum miss penalty is 2+`WORDS_PER_LINE` cycles.
- A response in the same cycle as the ready handshake is not accepted (the state is still REQ).
- Reset values:
  - state IDLE, beat 0, all valid 0, `drop` 0;
  - `mem_req_v_o`=0, `mem_addr_o`=0, `imem_data_o`=0, `imem_stall_o`=1.
  - The first post-reset cycle with `rst_i`=0 therefore misses.
- Reset asserted mid-REQ/FILL abandons the refill. Late beats are ignored because the state is IDLE. No partial line becomes valid.
- A flush in the same cycle as the final beat leaves the line invalid.
- A flush in IDLE forces stall=1 that cycle. The next cycle misses.

## Structure
- Add to the `rvga_types` package:
  - `icache_state_e` enum {IDLE, REQ, FILL};
  - default constants `ICACHE_SETS`, `ICACHE_WORDS_PER_LINE`.
- Split into two sub-modules:
  - `icache_ctl`: FSM, beat counter, `drop` flag, stall and handshake outputs.
  - `icache_dp`: valid/tag/data arrays, address split, hit compare, word mux, latched line address.
- The top-level `icache` only instantiates and wires the two.

## Test plan
- Cold miss:
  - stimulus: after reset, addr 0x0000_0104; ready=1 on the first REQ cycle; beats 0xA0..0xA3 back-to-back.
  - response: `mem_addr_o`=0x0000_0100; stall=1 for 6 cycles; then data 0xA1 with stall=0.
- Line hits: addrs 0x100, 0x108, 0x10C on consecutive cycles → 0xA0, 0xA2, 0xA3 with stall=0 and no `mem_req_v_o`.
- Conflict eviction:
  - stimulus: addr 0x0000_0200 (same index, tag 0x2) and refill; then addr 0x100 again.
  - response: 0x100 misses again with `mem_addr_o`=0x100.
- Backpressure:
  - stimulus: hold `mem_req_ready_i`=0 for 3 cycles; inject a stray `mem_resp_v_i` during REQ.
  - response: `mem_req_v_o`/`mem_addr_o` stay stable; the stray beat is not written; the fill data is correct.
- Flush during fill:
  - stimulus: `flush_i` pulse on beat 2.
  - response: the fill completes; the next lookup of the same address misses and a new request is issued.
  - also: `flush_i` in the final-beat cycle → line invalid.
- Reset mid-fill:
  - stimulus: `rst_i` after beat 1; then continued beats; then lookup of the same address.
  - response: `mem_req_v_o`=0, stall=1, state IDLE; the lookup misses.
